// File: rtl/aor_key_sweep_ctrl_pkg.sv
// Shared types and default sizes for the key-sweep controller.
// CORRECT_KEY is the unlocking key of the reference locked adder.
package aor_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        APPLY,
        SETTLE,
        CHECK,
        REPORT,
        FIN
    } sweep_state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_KEY_W      = 32;
    localparam int DEF_NUM_PAIRS  = 5000;
    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_NUM_KEYS   = 16;
    localparam int DEF_KIDX_W     = 4;
    localparam int DEF_SETTLE_CYC = 1;
    localparam int DEF_CNT_W      = 17;

    localparam logic [31:0] CORRECT_KEY = 32'hD7D41D23;

endpackage

// File: rtl/aor_key_sweep_ctrl_if.sv
// Vector-memory read port and locked-adder drive/sense signals.
// master = sweep controller, slave = memory + adder side.
interface aor_key_sweep_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int KEY_W  = 32,
    parameter int ADDR_W = 14
);
    logic              vec_rd_en;
    logic [ADDR_W-1:0] vec_rd_addr;
    logic [DATA_W-1:0] vec_rd_data;
    logic [DATA_W-1:0] dut_a;
    logic [DATA_W-1:0] dut_b;
    logic [KEY_W-1:0]  dut_key;
    logic [DATA_W:0]   dut_sum;

    modport master (
        output vec_rd_en, vec_rd_addr, dut_a, dut_b, dut_key,
        input  vec_rd_data, dut_sum
    );

    modport slave (
        input  vec_rd_en, vec_rd_addr, dut_a, dut_b, dut_key,
        output vec_rd_data, dut_sum
    );
endinterface

// File: rtl/aor_key_sweep_ctrl_popcount.sv
// Combinational population count of a W-bit vector.
module aor_popcount #(
    parameter int W  = 17,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(din[i]);
        end
    end
endmodule

// File: rtl/aor_key_sweep_ctrl.sv
// Key-sweep sequencer: for each table key, drives every stored operand pair
// into the locked adder and accumulates mismatch / flipped-bit counts.
module aor_key_sweep_ctrl
    import aor_sweep_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int KEY_W      = DEF_KEY_W,
    parameter int NUM_PAIRS  = DEF_NUM_PAIRS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int KIDX_W     = DEF_KIDX_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KIDX_W:0]   num_keys,
    input  logic              key_wr_en,
    input  logic [KIDX_W-1:0] key_wr_idx,
    input  logic [KEY_W-1:0]  key_wr_data,
    aor_key_sweep_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              rpt_valid,
    output logic [KIDX_W-1:0] rpt_key_idx,
    output logic [CNT_W-1:0]  rpt_err_vecs,
    output logic [CNT_W-1:0]  rpt_err_bits
);
    localparam int PC_W  = $clog2(DATA_W + 2);
    localparam int PI_W  = ADDR_W - 1;
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [PI_W-1:0]  LAST_PAIR   = PI_W'(NUM_PAIRS - 1);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC - 1);
    localparam logic [KIDX_W:0]  MAX_KEYS    = (KIDX_W + 1)'(NUM_KEYS);

    sweep_state_e      state_q, state_d;
    logic [KIDX_W:0]   nk_q, nk_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    logic [PI_W-1:0]   pair_q, pair_d;
    logic [3:0]        settle_q, settle_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W:0]   gold_q, gold_d;
    logic [CNT_W-1:0]  vecs_q, vecs_d, bits_q, bits_d;
    logic              busy_q, busy_d, done_q, done_d, rv_q, rv_d;
    logic [KIDX_W-1:0] rk_q, rk_d;
    logic [CNT_W-1:0]  rvecs_q, rvecs_d, rbits_q, rbits_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] da_q, da_d, db_q, db_d;
    logic [KEY_W-1:0]  dk_q, dk_d;
    logic [KEY_W-1:0]  key_tab_q [NUM_KEYS];

    logic [DATA_W:0]   diff;
    logic [PC_W-1:0]   pc;
    logic [SUM_W-1:0]  bits_sum;
    logic [CNT_W-1:0]  vecs_n, bits_n;

    // Table is deliberately left out of reset so keys survive an aborted sweep.
    always_ff @(posedge clk) begin
        if (key_wr_en && !busy_q) key_tab_q[key_wr_idx] <= key_wr_data;
    end

    assign diff = bus.dut_sum ^ gold_q;

    aor_popcount #(.W(DATA_W + 1), .CW(PC_W)) u_pop (.din(diff), .cnt(pc));

    always_comb begin
        bits_sum = SUM_W'(bits_q) + SUM_W'(pc);
        vecs_n   = ((|diff) && vecs_q != CNT_MAX) ? vecs_q + CNT_W'(1) : vecs_q;
        bits_n   = (bits_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bits_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d  = state_q;  nk_d    = nk_q;    kidx_d   = kidx_q;
        pair_d   = pair_q;   settle_d = settle_q; a_d    = a_q;
        gold_d   = gold_q;   vecs_d  = vecs_q;  bits_d   = bits_q;
        busy_d   = busy_q;   done_d  = 1'b0;    rv_d     = 1'b0;
        rk_d     = rk_q;     rvecs_d = rvecs_q; rbits_d  = rbits_q;
        rd_en_d  = 1'b0;     addr_d  = addr_q;
        da_d     = da_q;     db_d    = db_q;    dk_d     = dk_q;
        case (state_q)
            IDLE: if (start) begin
                if (num_keys == '0 || num_keys > MAX_KEYS) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD_A;
                    nk_d    = num_keys;
                    kidx_d  = '0;
                    pair_d  = '0;
                    vecs_d  = '0;
                    bits_d  = '0;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                end
            end
            RD_A: begin
                state_d = RD_B;
                rd_en_d = 1'b1;
                addr_d  = {pair_q, 1'b1};
            end
            RD_B: begin
                state_d = APPLY;
                a_d     = bus.vec_rd_data;
            end
            APPLY: begin
                state_d  = SETTLE;
                da_d     = a_q;
                db_d     = bus.vec_rd_data;
                dk_d     = key_tab_q[kidx_q];
                gold_d   = {1'b0, a_q} + {1'b0, bus.vec_rd_data};
                settle_d = SETTLE_INIT;
            end
            SETTLE: begin
                if (settle_q == '0) state_d = CHECK;
                else settle_d = settle_q - 4'd1;
            end
            CHECK: begin
                if (pair_q != LAST_PAIR) begin
                    state_d = RD_A;
                    pair_d  = pair_q + PI_W'(1);
                    vecs_d  = vecs_n;
                    bits_d  = bits_n;
                    rd_en_d = 1'b1;
                    addr_d  = {pair_q + PI_W'(1), 1'b0};
                end else begin
                    // Report fields load here so rpt_valid lines up with REPORT.
                    state_d = REPORT;
                    rv_d    = 1'b1;
                    rk_d    = kidx_q;
                    rvecs_d = vecs_n;
                    rbits_d = bits_n;
                    vecs_d  = '0;
                    bits_d  = '0;
                    pair_d  = '0;
                end
            end
            REPORT: begin
                if ((KIDX_W + 1)'(kidx_q) + (KIDX_W + 1)'(1) < nk_q) begin
                    state_d = RD_A;
                    kidx_d  = kidx_q + KIDX_W'(1);
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  nk_q    <= '0;   kidx_q  <= '0;
            pair_q  <= '0;    settle_q <= '0;  a_q     <= '0;
            gold_q  <= '0;    vecs_q  <= '0;   bits_q  <= '0;
            busy_q  <= 1'b0;  done_q  <= 1'b0; rv_q    <= 1'b0;
            rk_q    <= '0;    rvecs_q <= '0;   rbits_q <= '0;
            rd_en_q <= 1'b0;  addr_q  <= '0;
            da_q    <= '0;    db_q    <= '0;   dk_q    <= '0;
        end else begin
            state_q <= state_d; nk_q    <= nk_d;    kidx_q  <= kidx_d;
            pair_q  <= pair_d;  settle_q <= settle_d; a_q   <= a_d;
            gold_q  <= gold_d;  vecs_q  <= vecs_d;  bits_q  <= bits_d;
            busy_q  <= busy_d;  done_q  <= done_d;  rv_q    <= rv_d;
            rk_q    <= rk_d;    rvecs_q <= rvecs_d; rbits_q <= rbits_d;
            rd_en_q <= rd_en_d; addr_q  <= addr_d;
            da_q    <= da_d;    db_q    <= db_d;    dk_q    <= dk_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign rpt_valid       = rv_q;
    assign rpt_key_idx     = rk_q;
    assign rpt_err_vecs    = rvecs_q;
    assign rpt_err_bits    = rbits_q;
    assign bus.vec_rd_en   = rd_en_q;
    assign bus.vec_rd_addr = addr_q;
    assign bus.dut_a       = da_q;
    assign bus.dut_b       = db_q;
    assign bus.dut_key     = dk_q;
endmodule

// File: doc/aor_key_sweep_ctrl.md
Name: aor_key_sweep_ctrl

Overview:
Sequences key-sweep characterisation of a key-locked 16-bit adder netlist (e.g. carry_lookahead_adder16_aor_enc32) in hardware.
- For each key in a programmable table, applies every operand pair from an external vector memory to the locked adder and compares the locked sum against a golden A+B.
- Reports, per key, the count of corrupted vectors and the total flipped output bits (Hamming distance).
- Sits between the vector RAM, the locked adder instance and the on-chip results/monitor logic.

Parameters:
DATA_W, 16, operand width; sum is DATA_W+1 bits
KEY_W, 32, lock key width
NUM_PAIRS, 5000, operand pairs per key pass; vector memory holds 2*NUM_PAIRS words
ADDR_W, 14, vector memory address width
NUM_KEYS, 16, key table depth
KIDX_W, 4, key index width
SETTLE_CYC, 1, wait cycles after driving the adder before sampling (1..15)
CNT_W, 17, width of error counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins sweep of keys 0..num_keys-1
num_keys  in  KIDX_W+1  keys to sweep, 1..NUM_KEYS; sampled at start
key_wr_en  in  1  key table write strobe
key_wr_idx  in  KIDX_W  key table write index
key_wr_data  in  KEY_W  key value
vec_rd_en  out  1  vector memory read enable
vec_rd_addr  out  ADDR_W  vector memory address
vec_rd_data  in  DATA_W  read data, valid 1 cycle after vec_rd_en
dut_a  out  DATA_W  adder operand A (add1_i)
dut_b  out  DATA_W  adder operand B (add2_i)
dut_key  out  KEY_W  adder keyinput
dut_sum  in  DATA_W+1  adder result_o
busy  out  1  sweep in progress
done  out  1  one-cycle pulse after last report
rpt_valid  out  1  one-cycle pulse per completed key
rpt_key_idx  out  KIDX_W  key index being reported
rpt_err_vecs  out  CNT_W  vectors with dut_sum != golden
rpt_err_bits  out  CNT_W  sum of popcount(dut_sum ^ golden)

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: busy, done, rpt_*, vec_rd_en, vec_rd_addr, dut_a, dut_b, dut_key.
  - Counters and indices 0. Key table is not cleared.
- Asserting rst_n low mid-sweep aborts immediately. No partial report. No done pulse.
- Key table writes are accepted only when busy=0; ignored while busy.
- start is ignored while busy. With num_keys=0 or num_keys>NUM_KEYS, start produces only a done pulse on the next cycle and no reports.
- FSM, per vector pair k (addresses 2k, 2k+1):
  - IDLE: on start, latch num_keys, clear indices, busy=1 -> RD_A.
  - RD_A: vec_rd_en=1, addr=2k -> RD_B.
  - RD_B: vec_rd_en=1, addr=2k+1; capture A -> APPLY.
  - APPLY: capture B; drive dut_a, dut_b, dut_key=table[key_idx]; golden = zero-extended A+B (17-bit, carry kept) -> SETTLE.
  - SETTLE: hold dut_* for SETTLE_CYC cycles -> CHECK.
  - CHECK: sample dut_sum. If mismatch, err_vecs+=1. err_bits+=popcount(xor). Both counters saturate at all-ones.
    - If k<NUM_PAIRS-1: k++ -> RD_A.
    - Else -> REPORT.
  - REPORT: rpt_valid=1 with rpt_key_idx and counters for one cycle; clear counters and k.
    - If key_idx<num_keys-1: key_idx++ -> RD_A.
    - Else -> FIN.
  - FIN: done=1, busy=0 -> IDLE.
- Per-pair latency: 4+SETTLE_CYC cycles. Per-key cost: NUM_PAIRS*(4+SETTLE_CYC)+1 cycles.
- dut_a, dut_b and dut_key hold their last values between pairs and after done.
- rpt_* fields hold their values after rpt_valid until the next report.

Decomposition:
- Package aor_sweep_pkg: FSM state enum (IDLE, RD_A, RD_B, APPLY, SETTLE, CHECK, REPORT, FIN), default width constants, and the CORRECT_KEY constant 32'hD7D41D23 for benches.
- Sub-module aor_popcount: combinational popcount of the DATA_W+1-bit XOR, output width clog2(DATA_W+2).

Test Plan:
1. num_keys=1, key0=D7D41D23, ideal DUT model, NUM_PAIRS=4, SETTLE_CYC=1 -> one rpt_valid with err_vecs=0 and err_bits=0; done at cycle 4*5+2 after start.
2. key0=D7D41D23, key1=D7D41D03; DUT model XORs bit0 when key≠correct; 4 pairs -> reports (0,0,0) then (1,4,4), then done.
3. Carry: pair FFFF+0001 with DUT returning 0x00000 -> golden 0x10000; report err_vecs=1, err_bits=1.
4. rst_n low during key1 CHECK -> busy=0, no rpt_valid, no done. After release, the same start yields reports identical to scenario 2.
5. start and key_wr_en pulsed while busy -> no restart; table unchanged (confirmed by the report values). num_keys=0 -> done only, next cycle.
6. Saturation: CNT_W=4, all 20 vectors corrupt 3 bits -> err_vecs=15, err_bits=15.
